dhcp_tx: RTL

//  Builds the DHCP client payload (DISCOVER or REQUEST) as a 16-bit word stream for the UDP/IP TX path.
//  It is the transmit-side counterpart of the DHCP receive parser and uses the same word/byte framing.

---
 rtl/dhcp_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/dhcp_tx.sv
// dhcp_tx: builds the DHCP client DISCOVER/REQUEST payload as a 16-bit word stream (byte0 in [7:0]).
// Define DHCP_FULL_BOOTP_EN to emit the full BOOTP layout (sname/file padding and magic cookie).
module dhcp_tx #(
  parameter logic [7:0] HTYPE     = 8'h01,
  parameter logic [7:0] HLEN      = 8'h06,
  parameter logic       BCAST_FLG = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_discover,
  input  logic        start_request,
  input  logic [31:0] xid,
  input  logic [47:0] mac,
  input  logic [31:0] reqip,
  input  logic [31:0] serverid,
  input  logic        ready,
  output logic        validout,
  output logic        sof,
  output logic        eof,
  output logic [15:0] dataout,
  output logic [15:0] payload_len,
  output logic        busy,
  output logic        done
);

`ifdef DHCP_FULL_BOOTP_EN
  localparam logic [15:0] LEN_DISC = 16'd244;
  localparam logic [15:0] LEN_REQ  = 16'd256;
`else
  localparam logic [15:0] LEN_DISC = 16'd48;
  localparam logic [15:0] LEN_REQ  = 16'd60;
`endif

  typedef enum logic [2:0] {
    IDLE,
    HDR,
`ifdef DHCP_FULL_BOOTP_EN
    PAD,
    COOKIE,
`endif
    OPT,
    FIN
  } state_t;

  state_t      state_reg, state_next;
  logic [6:0]  cnt_reg, cnt_next;
  logic        load;
  logic        req_reg;
  logic [31:0] xid_reg, reqip_reg, serverid_reg;
  logic [47:0] mac_reg;
  logic [15:0] hdr_word, opt_word, len_word;
  logic [6:0]  opt_last;

  assign len_word = req_reg ? LEN_REQ : LEN_DISC;
  assign opt_last = req_reg ? 7'd7 : 7'd1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 7'd0;
      req_reg      <= 1'b0;
      xid_reg      <= 32'h0;
      mac_reg      <= 48'h0;
      reqip_reg    <= 32'h0;
      serverid_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        // DISCOVER takes priority when both starts arrive together
        req_reg      <= !start_discover;
        xid_reg      <= xid;
        mac_reg      <= mac;
        reqip_reg    <= reqip;
        serverid_reg <= serverid;
      end
    end
  end

  always_comb begin
    hdr_word = 16'h0000;
    case (cnt_reg)
      7'd0:  hdr_word = {HTYPE, 8'h01};
      7'd1:  hdr_word = {8'h00, HLEN};
      7'd2:  hdr_word = xid_reg[15:0];
      7'd3:  hdr_word = xid_reg[31:16];
      7'd5:  hdr_word = BCAST_FLG ? 16'h0080 : 16'h0000;
      7'd14: hdr_word = mac_reg[15:0];
      7'd15: hdr_word = mac_reg[31:16];
      7'd16: hdr_word = mac_reg[47:32];
      default: hdr_word = 16'h0000;
    endcase
  end

  // Option bytes: 35 01 t | 32 04 reqip | 36 04 serverid | FF, packed two per word
  always_comb begin
    opt_word = 16'h0000;
    if (req_reg) begin
      case (cnt_reg[2:0])
        3'd0: opt_word = 16'h0135;
        3'd1: opt_word = 16'h3203;
        3'd2: opt_word = {reqip_reg[7:0], 8'h04};
        3'd3: opt_word = {reqip_reg[23:16], reqip_reg[15:8]};
        3'd4: opt_word = {8'h36, reqip_reg[31:24]};
        3'd5: opt_word = {serverid_reg[7:0], 8'h04};
        3'd6: opt_word = {serverid_reg[23:16], serverid_reg[15:8]};
        default: opt_word = {8'hFF, serverid_reg[31:24]};
      endcase
    end else begin
      opt_word = cnt_reg[0] ? 16'hFF01 : 16'h0135;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    load        = 1'b0;
    validout    = 1'b0;
    sof         = 1'b0;
    eof         = 1'b0;
    dataout     = 16'h0000;
    payload_len = 16'h0000;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE, FIN: begin
        if (state_reg == FIN) begin
          done        = 1'b1;
          payload_len = len_word;
          state_next  = IDLE;
        end
        if (start_discover || start_request) begin
          load       = 1'b1;
          state_next = HDR;
          cnt_next   = 7'd0;
        end
      end
      HDR: begin
        validout    = 1'b1;
        busy        = 1'b1;
        payload_len = len_word;
        dataout     = hdr_word;
        sof         = (cnt_reg == 7'd0);
        if (ready) begin
          if (cnt_reg == 7'd21) begin
            cnt_next   = 7'd0;
`ifdef DHCP_FULL_BOOTP_EN
            state_next = PAD;
`else
            state_next = OPT;
`endif
          end else begin
            cnt_next = cnt_reg + 7'd1;
          end
        end
      end
`ifdef DHCP_FULL_BOOTP_EN
      PAD: begin
        validout    = 1'b1;
        busy        = 1'b1;
        payload_len = len_word;
        if (ready) begin
          if (cnt_reg == 7'd95) begin
            cnt_next   = 7'd0;
            state_next = COOKIE;
          end else begin
            cnt_next = cnt_reg + 7'd1;
          end
        end
      end
      COOKIE: begin
        validout    = 1'b1;
        busy        = 1'b1;
        payload_len = len_word;
        dataout     = cnt_reg[0] ? 16'h6353 : 16'h8263;
        if (ready) begin
          if (cnt_reg == 7'd1) begin
            cnt_next   = 7'd0;
            state_next = OPT;
          end else begin
            cnt_next = cnt_reg + 7'd1;
          end
        end
      end
`endif
      OPT: begin
        validout    = 1'b1;
        busy        = 1'b1;
        payload_len = len_word;
        dataout     = opt_word;
        eof         = (cnt_reg == opt_last);
        if (ready) begin
          if (cnt_reg == opt_last) begin
            cnt_next   = 7'd0;
            state_next = FIN;
          end else begin
            cnt_next = cnt_reg + 7'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
